// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads the instruction memory from a little-endian byte stream
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing 32-bit sum check, CHK state, err).
// Ports:
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   start, num_words       begin a load of num_words words (clamped to DEPTH)
//   byte_valid, byte_data  incoming program bytes, little-endian within a word
//   byte_ready             a byte transfers on byte_valid && byte_ready
//   wr_en, wr_addr, wr_data  instruction memory write port (one-cycle strobe)
//   busy, cpu_hold         load in progress / hold the core in reset
//   done, err              last load completed / checksum mismatch

module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

  localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] WORD_ONE = (ADDR_W+1)'(1);

  state_t            state, state_n;
  logic [1:0]        byte_idx;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   num_lat;
  logic [ADDR_W:0]   num_eff;
  logic              xfer;
  logic              last_byte;
  logic              last_word;

  assign num_eff   = (num_words > DEPTH_W) ? DEPTH_W : num_words;
  assign xfer      = byte_valid && byte_ready;
  assign last_byte = (byte_idx == 2'd3);
  // Evaluated in WRITE: this write completes the requested word count.
  assign last_word = ((word_cnt + WORD_ONE) == num_lat);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_n = (num_eff == '0) ? DONE : RECV;
      end
      RECV: begin
        if (xfer && last_byte) state_n = WRITE;
      end
      WRITE: begin
        if (!last_word) state_n = RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else            state_n = CHK;
`else
        else            state_n = DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer && last_byte) state_n = DONE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Output logic (purely state-decoded)
  always_comb begin
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      RECV:  begin byte_ready = 1'b1; busy = 1'b1; end
      WRITE: begin wr_en = 1'b1;      busy = 1'b1; end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:   begin byte_ready = 1'b1; busy = 1'b1; end
`endif
      DONE:  done = 1'b1;
      default: ;
    endcase
    cpu_hold = busy;
  end

  // Word assembly and write addressing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= '0;
      word_cnt <= '0;
      num_lat  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            byte_idx <= '0;
            word_cnt <= '0;
            wr_addr  <= '0;
            num_lat  <= num_eff;
          end
        end
        RECV: begin
          if (xfer) begin
            wr_data[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        WRITE: begin
          word_cnt <= word_cnt + WORD_ONE;
          // Hold the address on the final write so a full-depth load never wraps.
          if (!last_word) wr_addr <= wr_addr + ADDR_W'(1);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) byte_idx <= byte_idx + 2'd1;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic [23:0] chk_lo;

  // Running sum of written words, compared with the trailing expected sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum    <= '0;
      chk_lo <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sum <= '0;
            err <= 1'b0;
          end
        end
        WRITE: sum <= sum + wr_data;
        CHK: begin
          if (xfer) begin
            if (last_byte) err <= ({byte_data, chk_lo} != sum);
            else           chk_lo[{byte_idx, 3'b000} +: 8] <= byte_data;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader

module tb_imem_loader;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int DONE_LAT = 14;
`else
  localparam int DONE_LAT = 10;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_words = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready, wr_en, busy, cpu_hold, done, err;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  int errors = 0;
  int checks = 0;
  int tmo_cnt = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int hold_mis = 0;
  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];
  logic [7:0]        stim_q[$];

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write and status monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (busy === 1'b1) busy_cnt++;
    if (cpu_hold !== busy) hold_mis++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // Reference model: word i is the little-endian combination of stim bytes 4i..4i+3.
  function automatic logic [31:0] model_word(input int i);
    return 32'(stim_q[4*i]) + (32'(stim_q[4*i+1]) << 8) +
           (32'(stim_q[4*i+2]) << 16) + (32'(stim_q[4*i+3]) << 24);
  endfunction

  function automatic logic [31:0] model_sum(input int n);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = s + model_word(i);
    return s;
  endfunction

  task automatic fill_stim(input int nb);
    stim_q.delete();
    for (int i = 0; i < nb; i++) stim_q.push_back(8'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_words = (ADDR_W+1)'(n);
    @(negedge clk);
    start = 1'b0;
    num_words = (ADDR_W+1)'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      byte_data = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data = b;
    t = 0;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) tmo_cnt++;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int count, input int gap_max);
    for (int i = first; i < first + count; i++)
      send_byte(stim_q[i], int'($urandom_range(gap_max, 0)));
  endtask

  task automatic wait_done(input int lim);
    int t;
    t = 0;
    while (done !== 1'b1 && t < lim) begin
      @(negedge clk);
      t++;
    end
    if (t >= lim) tmo_cnt++;
  endtask

  // Sends the trailing sum when the checksum build is used, then waits for done.
  task automatic finish_load(input int n);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] s;
    s = model_sum(n);
    if (n > 0) for (int k = 0; k < 4; k++) send_byte(s[8*k +: 8], 0);
`endif
    wait_done(40 + 6 * n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b cpu_hold=%b expected 0 0", busy, cpu_hold); end
    checks++; if (wr_en !== 1'b0 || byte_ready !== 1'b0) begin errors++; $display("FAIL reset_strobes: wr_en=%b byte_ready=%b expected 0 0", wr_en, byte_ready); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: done=%b err=%b expected 0 0", done, err); end
    checks++; if (wr_addr !== '0 || wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr: wr_addr=%0d wr_data=%h expected 0 0", wr_addr, wr_data); end
    do_reset();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_basic();
    int base, t_first;
    // Bytes offered in IDLE must be ignored.
    byte_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      byte_data = 8'($urandom);
      checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: byte_ready=%b expected 0", byte_ready); end
      @(negedge clk);
    end
    stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h10, 8'h00};
    base = wq_addr.size();
    do_start(2);
    t_first = cyc;
    checks++; if (byte_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_recv: byte_ready=%b busy=%b expected 1 1", byte_ready, busy); end
    send_range(0, 8, 0);
    finish_load(2);
    checks++; if (cyc - t_first != DONE_LAT) begin errors++; $display("FAIL basic_done_latency: got %0d cycles expected %0d", cyc - t_first, DONE_LAT); end
    checks++; if (wq_addr.size() - base != 2) begin errors++; $display("FAIL basic_count: got %0d writes expected 2", wq_addr.size() - base); end
    else begin
      checks++; if (wq_addr[base] !== 6'd0 || wq_data[base] !== 32'h00000013) begin errors++; $display("FAIL basic_w0: addr=%0d data=%h expected 0 00000013", wq_addr[base], wq_data[base]); end
      checks++; if (wq_addr[base+1] !== 6'd1 || wq_data[base+1] !== 32'h001000B3) begin errors++; $display("FAIL basic_w1: addr=%0d data=%h expected 1 001000b3", wq_addr[base+1], wq_data[base+1]); end
    end
    checks++; if (wr_addr !== 6'd1 || err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_final: wr_addr=%0d err=%b busy=%b expected 1 0 0", wr_addr, err, busy); end
    checks++; if (tmo_cnt != 0) begin errors++; $display("FAIL basic_timeout: %0d timeouts expected 0", tmo_cnt); end
    tmo_cnt = 0;
  endtask

  task automatic test_gaps();
    int base;
    stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h10, 8'h00};
    base = wq_addr.size();
    do_start(2);
    for (int i = 0; i < 8; i++) send_byte(stim_q[i], 1);
    finish_load(2);
    checks++; if (wq_addr.size() - base != 2) begin errors++; $display("FAIL gaps_count: got %0d writes expected 2", wq_addr.size() - base); end
    else for (int i = 0; i < 2; i++) begin
      checks++; if (wq_addr[base+i] !== ADDR_W'(i) || wq_data[base+i] !== model_word(i)) begin errors++; $display("FAIL gaps_w%0d: addr=%0d data=%h expected %0d %h", i, wq_addr[base+i], wq_data[base+i], i, model_word(i)); end
    end
    checks++; if (tmo_cnt != 0) begin errors++; $display("FAIL gaps_timeout: %0d timeouts expected 0", tmo_cnt); end
    tmo_cnt = 0;
  endtask

  task automatic test_zero();
    int base, bc;
    do_reset();
    base = wq_addr.size();
    bc = busy_cnt;
    do_start(0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: done=%b expected 1", done); end
    repeat (3) @(negedge clk);
    checks++; if (busy_cnt != bc) begin errors++; $display("FAIL zero_busy: busy high %0d cycles expected 0", busy_cnt - bc); end
    checks++; if (wq_addr.size() != base) begin errors++; $display("FAIL zero_writes: got %0d writes expected 0", wq_addr.size() - base); end
  endtask

  task automatic test_clamp();
    int base;
    fill_stim(256);
    base = wq_addr.size();
    do_start(100);
    send_range(0, 256, 0);
    finish_load(64);
    checks++; if (wq_addr.size() - base != 64) begin errors++; $display("FAIL clamp_count: got %0d writes expected 64", wq_addr.size() - base); end
    else begin
      for (int i = 0; i < 64; i++) begin
        checks++; if (wq_addr[base+i] !== ADDR_W'(i) || wq_data[base+i] !== model_word(i)) begin errors++; $display("FAIL clamp_w%0d: addr=%0d data=%h expected %0d %h", i, wq_addr[base+i], wq_data[base+i], i, model_word(i)); end
      end
      checks++; if (wq_addr[base+63] !== 6'd63 || wr_addr !== 6'd63) begin errors++; $display("FAIL clamp_last: last=%0d wr_addr=%0d expected 63 63", wq_addr[base+63], wr_addr); end
    end
    checks++; if (tmo_cnt != 0) begin errors++; $display("FAIL clamp_timeout: %0d timeouts expected 0", tmo_cnt); end
    tmo_cnt = 0;
  endtask

  task automatic test_random();
    int base, n;
    for (int it = 0; it < 4; it++) begin
      n = int'($urandom_range(12, 1));
      fill_stim(4 * n);
      base = wq_addr.size();
      do_start(n);
      send_range(0, 4 * n, 2);
      finish_load(n);
      checks++; if (wq_addr.size() - base != n) begin errors++; $display("FAIL rand%0d_count: got %0d writes expected %0d", it, wq_addr.size() - base, n); end
      else for (int i = 0; i < n; i++) begin
        checks++; if (wq_addr[base+i] !== ADDR_W'(i) || wq_data[base+i] !== model_word(i)) begin errors++; $display("FAIL rand%0d_w%0d: addr=%0d data=%h expected %0d %h", it, i, wq_addr[base+i], wq_data[base+i], i, model_word(i)); end
      end
    end
    checks++; if (tmo_cnt != 0 || hold_mis != 0) begin errors++; $display("FAIL rand_status: timeouts=%0d cpu_hold_mismatches=%0d expected 0 0", tmo_cnt, hold_mis); end
    tmo_cnt = 0;
  endtask

  task automatic test_reset_mid();
    int base;
    fill_stim(12);
    base = wq_addr.size();
    do_start(3);
    send_range(0, 6, 0);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || byte_ready !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_async: busy=%b byte_ready=%b wr_en=%b expected 0 0 0", busy, byte_ready, wr_en); end
    checks++; if (wr_addr !== '0 || wr_data !== 32'h0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_regs: wr_addr=%0d wr_data=%h done=%b expected 0 0 0", wr_addr, wr_data, done); end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (wq_addr.size() - base != 1) begin errors++; $display("FAIL rstmid_writes: got %0d writes expected 1", wq_addr.size() - base); end
    fill_stim(8);
    base = wq_addr.size();
    do_start(2);
    send_range(0, 8, 1);
    finish_load(2);
    checks++; if (wq_addr.size() - base != 2) begin errors++; $display("FAIL rstmid_reload_count: got %0d writes expected 2", wq_addr.size() - base); end
    else for (int i = 0; i < 2; i++) begin
      checks++; if (wq_addr[base+i] !== ADDR_W'(i) || wq_data[base+i] !== model_word(i)) begin errors++; $display("FAIL rstmid_w%0d: addr=%0d data=%h expected %0d %h", i, wq_addr[base+i], wq_data[base+i], i, model_word(i)); end
    end
    tmo_cnt = 0;
  endtask

  task automatic test_start_ignored();
    int base;
    fill_stim(12);
    base = wq_addr.size();
    do_start(3);
    send_range(0, 2, 0);
    start = 1'b1;
    num_words = (ADDR_W+1)'(1);
    @(negedge clk);
    start = 1'b0;
    send_range(2, 10, 1);
    finish_load(3);
    checks++; if (wq_addr.size() - base != 3) begin errors++; $display("FAIL startign_count: got %0d writes expected 3", wq_addr.size() - base); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (wq_addr[base+i] !== ADDR_W'(i) || wq_data[base+i] !== model_word(i)) begin errors++; $display("FAIL startign_w%0d: addr=%0d data=%h expected %0d %h", i, wq_addr[base+i], wq_data[base+i], i, model_word(i)); end
    end
    checks++; if (tmo_cnt != 0) begin errors++; $display("FAIL startign_timeout: %0d timeouts expected 0", tmo_cnt); end
    tmo_cnt = 0;
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] good[4];
    logic [7:0] bad[4];
    good = '{8'hC6, 8'h00, 8'h10, 8'h00};
    bad  = '{8'hC7, 8'h00, 8'h10, 8'h00};
    stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h10, 8'h00};
    do_start(2);
    send_range(0, 8, 0);
    for (int k = 0; k < 4; k++) send_byte(good[k], 0);
    wait_done(40);
    checks++; if (err !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL chk_good: err=%b done=%b expected 0 1", err, done); end
    do_start(2);
    send_range(0, 8, 1);
    for (int k = 0; k < 4; k++) send_byte(bad[k], 1);
    wait_done(40);
    checks++; if (err !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL chk_bad: err=%b done=%b expected 1 1", err, done); end
    fill_stim(4);
    do_start(1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk_clear: err=%b expected 0", err); end
    send_range(0, 4, 0);
    finish_load(1);
    checks++; if (err !== 1'b0 || tmo_cnt != 0) begin errors++; $display("FAIL chk_final: err=%b timeouts=%0d expected 0 0", err, tmo_cnt); end
    tmo_cnt = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_zero();
    test_clamp();
    test_random();
    test_reset_mid();
    test_start_ignored();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, default 6, word-address width of the instruction memory being written.
REQ-002 Parameter: DEPTH, default 64, number of 32-bit words in the instruction memory.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  single-cycle request to begin a load; sampled only in IDLE or DONE.
REQ-007 num_words  input  ADDR_W+1  word count for the load; sampled in the cycle start is taken.
REQ-008 byte_valid  input  1  byte_data is valid.
REQ-009 byte_data  input  8  incoming program byte stream, little-endian within each word.
REQ-010 byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 wr_en  output  1  one-cycle write strobe to the instruction memory.
REQ-012 wr_addr  output  ADDR_W  word address for the write.
REQ-013 wr_data  output  32  assembled instruction word.
REQ-014 busy  output  1  a load is in progress.
REQ-015 cpu_hold  output  1  holds the core in reset while memory is being written; equals busy.
REQ-016 done  output  1  the last load completed; held until the next start or rst.
REQ-017 err  output  1  checksum mismatch, only under IMEM_LOADER_CHECKSUM_EN; tied 0 otherwise.

Function
REQ-018 States SHALL be IDLE, RECV, WRITE, CHK and DONE; CHK exists only under the macro.
REQ-019 IDLE/DONE + start: clear the byte index, word counter and wr_addr, latch num_words and go to RECV; if num_words==0, go directly to DONE.
REQ-020 num_words > DEPTH SHALL be clamped to DEPTH.
REQ-021 byte_ready SHALL be 1 only in RECV (and CHK); a byte transfers on byte_valid&&byte_ready.
REQ-022 A transfer with byte index k (0..3) SHALL write byte_data into wr_data[8k+7:8k]; the index then increments mod 4.
REQ-023 Accepting byte 3 SHALL move the FSM to WRITE; wr_en SHALL be high for exactly the next cycle, with wr_addr/wr_data stable.
REQ-024 After WRITE, wr_addr SHALL increment by one, and the word counter likewise; if the count equals the latched num_words, go to DONE (or CHK), else return to RECV.
REQ-025 Maximum throughput SHALL be one byte per cycle, i.e. 4 bytes + 1 write cycle = 5 cycles per word.
REQ-026 wr_addr SHALL never wrap; the last write address SHALL be num_words-1.
REQ-027 A start received while busy SHALL be ignored.
REQ-028 byte_valid outside RECV/CHK SHALL be ignored, and no byte SHALL be consumed.
REQ-029 busy SHALL be 1 in RECV, WRITE and CHK; done SHALL be 1 only in DONE.

Reset
REQ-030 rst SHALL asynchronously force IDLE, with wr_en=0, byte_ready=0, busy=0, cpu_hold=0, done=0, err=0, wr_addr=0, wr_data=0 and counters=0.
REQ-031 A reset mid-load SHALL discard the partial word; words already written are not rolled back.

Configuration
REQ-032 Macro IMEM_LOADER_CHECKSUM_EN defined: the block SHALL keep a 32-bit wrapping sum of all written words.
REQ-032a After the last word, CHK SHALL accept 4 more little-endian bytes as the expected sum.
REQ-032b If the expected sum differs from the running sum, err SHALL be set; either way the FSM then goes to DONE, and err is cleared on the next start.
REQ-033 Macro undefined: there SHALL be no CHK state or sum register, err SHALL be constant 0, and the FSM goes directly from the last WRITE to DONE.

Verification
REQ-034 rst, then start with num_words=2 and bytes 13,00,00,00,B3,00,10,00 sent back-to-back. Required response:
- wr_en pulses at addr 0 (data 0x00000013), then at addr 1 (data 0x001000B3).
- done=1 10 cycles after the first byte.
REQ-035 Same stream with byte_valid low on alternate cycles -> identical writes; no byte is lost or duplicated.
REQ-036 start with num_words=0 -> DONE the next cycle, no wr_en, busy never 1; with num_words=100 -> exactly 64 writes, last at addr 63.
REQ-037 rst asserted after 2 bytes of word 1 -> immediate IDLE, no further wr_en; a new start reloads from addr 0.
REQ-038 start pulsed during RECV -> ignored; wr_addr sequence unchanged.
REQ-039 With IMEM_LOADER_CHECKSUM_EN: words 0x00000013 and 0x001000B3, then checksum bytes C6,00,10,00 -> err=0; checksum bytes C7,00,10,00 -> err=1, done=1.
